rib_mailbox: RTL and testbench

- Multi-cycle RIB responder occupying one of the handshake slave slots (s6/s7 class) of the RIB interconnect.
- Gives the core a word-wide mailbox to a peripheral-side agent: a TX FIFO (bus to peripheral) and an RX FIFO (peripheral to bus), plus status/control registers and a level interrupt.
- Answers each bus request after a programmable number of wait states using the req/ready handshake.

---
 rtl/rib_mailbox.sv | 155 +++++++++++++++
 tb/tb_rib_mailbox.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rib_mailbox.sv
// rtl/rib_mailbox.sv - RIB handshake responder exposing TX/RX mailbox FIFOs, status/control and irq
module rib_mailbox #(
   parameter int WAIT_CYCLES = 2,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        ready_o,
   output logic        tx_valid_o,
   output logic [31:0] tx_data_o,
   input  logic        tx_ready_i,
   input  logic        rx_valid_i,
   input  logic [31:0] rx_data_i,
   output logic        rx_ready_o,
   output logic        irq_o
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0]       state;
   logic [3:0]       wait_cnt;
   logic             req_we;
   logic [1:0]       req_sel;
   logic [31:0]      req_data;

   logic [31:0]      tx_mem [FIFO_DEPTH];
   logic [31:0]      rx_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
   logic [CNT_W-1:0] tx_count, rx_count;
   logic             tx_ovf, rx_udf, irq_en;

   logic             resp, tx_full, tx_empty, rx_full, rx_empty;
   logic             wr_tx, rd_rx, wr_st, wr_ctl;
   logic             tx_push, tx_pop, rx_push, rx_pop;
   logic [31:0]      rx_head, rdata;
   logic             unused_addr;

   assign unused_addr = ^{addr_i[31:4], addr_i[1:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         wait_cnt <= '0;
         req_we   <= 1'b0;
         req_sel  <= '0;
         req_data <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_i) begin
                  req_we   <= we_i;
                  req_sel  <= addr_i[3:2];
                  req_data <= data_i;
                  wait_cnt <= 4'(WAIT_CYCLES);
                  state    <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
               end
            end
            ST_WAIT: begin
               // a withdrawn request is dropped before any side effect can happen
               if (!req_i) begin
                  state <= ST_IDLE;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
                  if (wait_cnt == 4'd1) state <= ST_RESP;
               end
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign resp     = (state == ST_RESP);
   assign wr_tx    = resp &  req_we & (req_sel == 2'd0);
   assign rd_rx    = resp & ~req_we & (req_sel == 2'd1);
   assign wr_st    = resp &  req_we & (req_sel == 2'd2);
   assign wr_ctl   = resp &  req_we & (req_sel == 2'd3);

   assign tx_full  = (tx_count == CNT_W'(FIFO_DEPTH));
   assign tx_empty = (tx_count == '0);
   assign rx_full  = (rx_count == CNT_W'(FIFO_DEPTH));
   assign rx_empty = (rx_count == '0);

   assign tx_push  = wr_tx & ~tx_full;
   assign tx_pop   = ~tx_empty & tx_ready_i;
   assign rx_push  = rx_valid_i & ~rx_full;
   assign rx_pop   = rd_rx & ~rx_empty;

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr] <= req_data;
      if (rx_push) rx_mem[rx_wr] <= rx_data_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_wr    <= '0;
         tx_rd    <= '0;
         tx_count <= '0;
         rx_wr    <= '0;
         rx_rd    <= '0;
         rx_count <= '0;
      end else begin
         if (tx_push) tx_wr <= tx_wr + 1'b1;
         if (tx_pop)  tx_rd <= tx_rd + 1'b1;
         if (rx_push) rx_wr <= rx_wr + 1'b1;
         if (rx_pop)  rx_rd <= rx_rd + 1'b1;
         tx_count <= tx_count + CNT_W'(tx_push) - CNT_W'(tx_pop);
         rx_count <= rx_count + CNT_W'(rx_push) - CNT_W'(rx_pop);
      end
   end

   // a W1C clear loses against a set event landing in the same cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_ovf <= 1'b0;
         rx_udf <= 1'b0;
         irq_en <= 1'b0;
         irq_o  <= 1'b0;
      end else begin
         tx_ovf <= (tx_ovf & ~(wr_st & req_data[4])) | (wr_tx & tx_full);
         rx_udf <= (rx_udf & ~(wr_st & req_data[5])) | (rd_rx & rx_empty);
         if (wr_ctl) irq_en <= req_data[0];
         irq_o  <= irq_en & ~rx_empty;
      end
   end

   assign rx_head = rx_empty ? '0 : rx_mem[rx_rd];

   always_comb begin
      rdata = '0;
      case (req_sel)
         2'd1:    rdata = rx_head;
         2'd2:    rdata = {8'd0, 8'(rx_count), 8'(tx_count), 2'b00, rx_udf, tx_ovf,
                           rx_empty, rx_full, tx_empty, tx_full};
         2'd3:    rdata = {31'd0, irq_en};
         default: rdata = '0;
      endcase
   end

   assign ready_o    = resp;
   assign data_o     = (resp & ~req_we) ? rdata : '0;
   assign tx_valid_o = ~tx_empty;
   assign tx_data_o  = tx_empty ? '0 : tx_mem[tx_rd];
   assign rx_ready_o = ~rx_full;

endmodule

// File: tb/tb_rib_mailbox.sv
// tb/tb_rib_mailbox.sv - randomized self-checking bench for rib_mailbox against a queue model
module tb_rib_mailbox;
   localparam int W = 2;
   localparam int D = 4;

   logic        clk = 1'b0;
   logic        rst, req_i, we_i, tx_ready_i, rx_valid_i;
   logic [31:0] addr_i, data_i, rx_data_i;
   logic [31:0] data_o, tx_data_o;
   logic        ready_o, tx_valid_o, rx_ready_o, irq_o;

   int total = 0;
   int bad   = 0;

   logic [31:0] tx_q[$];
   logic [31:0] rx_q[$];
   bit          m_ovf, m_udf, m_irq_en;

   rib_mailbox #(.WAIT_CYCLES(W), .FIFO_DEPTH(D)) dut (
      .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .data_i(data_i),
      .data_o(data_o), .ready_o(ready_o), .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o),
      .tx_ready_i(tx_ready_i), .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
      .rx_ready_o(rx_ready_o), .irq_o(irq_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] model_read(input logic [1:0] sel);
      logic [31:0] v;
      v = 0;
      case (sel)
         2'd1: v = (rx_q.size() == 0) ? 32'd0 : rx_q[0];
         2'd2: v = (rx_q.size() << 16) + (tx_q.size() << 8) + (m_udf ? 32 : 0) + (m_ovf ? 16 : 0)
                 + ((rx_q.size() == 0) ? 8 : 0) + ((rx_q.size() == D) ? 4 : 0)
                 + ((tx_q.size() == 0) ? 2 : 0) + ((tx_q.size() == D) ? 1 : 0);
         2'd3: v = m_irq_en ? 32'd1 : 32'd0;
         default: v = 0;
      endcase
      return v;
   endfunction

   task automatic model_apply(input logic we, input logic [1:0] sel, input logic [31:0] wd);
      case (sel)
         2'd0: if (we) begin
                  if (tx_q.size() == D) m_ovf = 1; else tx_q.push_back(wd);
               end
         2'd1: if (!we) begin
                  if (rx_q.size() == 0) m_udf = 1; else void'(rx_q.pop_front());
               end
         2'd2: if (we) begin
                  if (wd[4]) m_ovf = 0;
                  if (wd[5]) m_udf = 0;
               end
         default: if (we) m_irq_en = wd[0];
      endcase
   endtask

   task automatic model_reset();
      tx_q.delete();
      rx_q.delete();
      m_ovf = 0; m_udf = 0; m_irq_en = 0;
   endtask

   task automatic access(input logic we, input logic [1:0] sel, input logic [31:0] wd);
      logic [31:0] exp_rd, rd;
      bit got;
      exp_rd = model_read(sel);
      rd = 0; got = 0;
      req_i = 1; we_i = we; addr_i = $urandom; addr_i[3:2] = sel; data_i = wd;
      for (int k = 0; k < 20 && !got; k++) begin
         @(posedge clk); #1;
         total++;
         if (ready_o === 1'b1) begin
            got = 1; rd = data_o;
            if (k != W) begin bad++; $display("FAIL latency: got %0d want %0d", k, W); end
         end else if (data_o !== 32'd0) begin
            bad++; $display("FAIL data_idle: got %h want 0", data_o);
         end
      end
      req_i = 0; we_i = 0;
      total++;
      if (!got) begin bad++; $display("FAIL ready_timeout: got none want pulse"); end
      if (!we) begin
         total++;
         if (rd !== exp_rd) begin bad++; $display("FAIL read sel%0d: got %h want %h", sel, rd, exp_rd); end
      end
      model_apply(we, sel, wd);
      @(posedge clk); @(negedge clk);
   endtask

   task automatic check_lines();
      @(negedge clk);
      total += 4;
      if (irq_o !== (m_irq_en && rx_q.size() != 0)) begin bad++; $display("FAIL irq: got %b want %b", irq_o, m_irq_en && rx_q.size() != 0); end
      if (tx_valid_o !== (tx_q.size() != 0)) begin bad++; $display("FAIL tx_valid: got %b want %b", tx_valid_o, tx_q.size() != 0); end
      if (tx_data_o !== ((tx_q.size() == 0) ? 32'd0 : tx_q[0])) begin bad++; $display("FAIL tx_data: got %h", tx_data_o); end
      if (rx_ready_o !== (rx_q.size() != D)) begin bad++; $display("FAIL rx_ready: got %b want %b", rx_ready_o, rx_q.size() != D); end
   endtask

   task automatic periph_pop();
      total += 2;
      if (tx_valid_o !== (tx_q.size() != 0)) begin bad++; $display("FAIL pop_valid: got %b", tx_valid_o); end
      if (tx_data_o !== ((tx_q.size() == 0) ? 32'd0 : tx_q[0])) begin bad++; $display("FAIL pop_head: got %h", tx_data_o); end
      tx_ready_i = 1;
      @(negedge clk);
      tx_ready_i = 0;
      if (tx_q.size() != 0) void'(tx_q.pop_front());
   endtask

   task automatic periph_push(input logic [31:0] d);
      total++;
      if (rx_ready_o !== (rx_q.size() != D)) begin bad++; $display("FAIL push_ready: got %b", rx_ready_o); end
      rx_valid_i = 1; rx_data_i = d;
      @(negedge clk);
      rx_valid_i = 0;
      if (rx_q.size() != D) rx_q.push_back(d);
   endtask

   task automatic check_reset_outputs(input string tag);
      total += 6;
      if (ready_o !== 1'b0)     begin bad++; $display("FAIL %s ready: got %b want 0", tag, ready_o); end
      if (data_o !== 32'd0)     begin bad++; $display("FAIL %s data: got %h want 0", tag, data_o); end
      if (tx_valid_o !== 1'b0)  begin bad++; $display("FAIL %s tx_valid: got %b want 0", tag, tx_valid_o); end
      if (tx_data_o !== 32'd0)  begin bad++; $display("FAIL %s tx_data: got %h want 0", tag, tx_data_o); end
      if (rx_ready_o !== 1'b1)  begin bad++; $display("FAIL %s rx_ready: got %b want 1", tag, rx_ready_o); end
      if (irq_o !== 1'b0)       begin bad++; $display("FAIL %s irq: got %b want 0", tag, irq_o); end
   endtask

   task automatic test_reset();
      rst = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 0;
      check_reset_outputs("reset");
      model_reset();
      access(0, 2'd2, 0);
      total++;
      if (model_read(2'd2) !== 32'h0000_000A) begin bad++; $display("FAIL status_model: got %h want 0000000a", model_read(2'd2)); end
   endtask

   task automatic test_tx_overflow();
      logic [31:0] vals [5];
      vals = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
      foreach (vals[i]) access(1, 2'd0, vals[i]);
      access(0, 2'd2, 0);
      check_lines();
      repeat (D) periph_pop();
      check_lines();
      access(1, 2'd2, 32'h10);
      access(0, 2'd2, 0);
   endtask

   task automatic test_rx_irq();
      access(1, 2'd3, 32'h1);
      periph_push(32'hA5);
      total++;
      if (irq_o !== 1'b0) begin bad++; $display("FAIL irq_early: got %b want 0", irq_o); end
      check_lines();
      access(0, 2'd1, 0);
      check_lines();
      access(0, 2'd1, 0);
      access(0, 2'd2, 0);
      access(1, 2'd2, 32'h20);
      access(0, 2'd2, 0);
   endtask

   task automatic test_withdraw();
      @(negedge clk);
      req_i = 1; we_i = 1; addr_i = 32'h0; data_i = 32'hDEAD;
      @(posedge clk); #1;
      @(negedge clk);
      req_i = 0; we_i = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         total++;
         if (ready_o !== 1'b0) begin bad++; $display("FAIL withdraw_ready: got %b want 0", ready_o); end
      end
      @(negedge clk);
      access(0, 2'd2, 0);
   endtask

   task automatic test_back_to_back();
      int hits [$];
      logic [31:0] exp_rd;
      exp_rd = model_read(2'd2);
      req_i = 1; we_i = 0; addr_i = 32'h8; data_i = 0;
      for (int k = 0; k < 12 && hits.size() < 2; k++) begin
         @(posedge clk); #1;
         if (ready_o === 1'b1) begin
            hits.push_back(k);
            total++;
            if (data_o !== exp_rd) begin bad++; $display("FAIL b2b_data: got %h want %h", data_o, exp_rd); end
         end
      end
      req_i = 0;
      total += 2;
      if (hits.size() != 2) begin bad++; $display("FAIL b2b_count: got %0d want 2", hits.size()); end
      else if (hits[0] != W || hits[1] != 2 * W + 2) begin
         bad++; $display("FAIL b2b_timing: got %0d,%0d want %0d,%0d", hits[0], hits[1], W, 2 * W + 2);
      end
      @(posedge clk); #1;
      if (ready_o !== 1'b0) begin bad++; $display("FAIL b2b_tail: got %b want 0", ready_o); end
      @(negedge clk);
   endtask

   task automatic test_rx_full_collision();
      bit got;
      while (rx_q.size() < D) periph_push($urandom);
      check_lines();
      got = 0;
      req_i = 1; we_i = 0; addr_i = 32'h4;
      for (int k = 0; k < 20 && !got; k++) begin
         @(posedge clk); #1;
         if (ready_o === 1'b1) got = 1;
      end
      rx_valid_i = 1; rx_data_i = 32'hBEEF;
      total += 3;
      if (!got) begin bad++; $display("FAIL coll_timeout: got none want pulse"); end
      if (data_o !== rx_q[0]) begin bad++; $display("FAIL coll_data: got %h want %h", data_o, rx_q[0]); end
      if (rx_ready_o !== 1'b0) begin bad++; $display("FAIL coll_ready: got %b want 0", rx_ready_o); end
      req_i = 0;
      @(posedge clk); #1;
      rx_valid_i = 0;
      void'(rx_q.pop_front());
      total++;
      if (rx_ready_o !== 1'b1) begin bad++; $display("FAIL coll_ready_after: got %b want 1", rx_ready_o); end
      @(negedge clk);
      access(0, 2'd2, 0);
   endtask

   task automatic test_reset_mid();
      while (tx_q.size() != 0) periph_pop();
      access(1, 2'd0, 32'h1234);
      access(1, 2'd0, 32'h5678);
      req_i = 1; we_i = 1; addr_i = 32'h0; data_i = 32'h77;
      @(posedge clk); #1;
      rst = 1;
      @(posedge clk); #1;
      rst = 0; req_i = 0; we_i = 0;
      model_reset();
      check_reset_outputs("mid_reset");
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         total++;
         if (ready_o !== 1'b0) begin bad++; $display("FAIL mid_reset_pulse: got %b want 0", ready_o); end
      end
      @(negedge clk);
      access(0, 2'd2, 0);
      access(0, 2'd3, 0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 80; n++) begin
         case ($urandom_range(0, 3))
            0, 1: access(1'($urandom), 2'($urandom), $urandom);
            2:    periph_push($urandom);
            default: periph_pop();
         endcase
         check_lines();
      end
      access(0, 2'd2, 0);
   endtask

   initial begin
      rst = 1; req_i = 0; we_i = 0; addr_i = 0; data_i = 0;
      tx_ready_i = 0; rx_valid_i = 0; rx_data_i = 0;
      model_reset();
      @(negedge clk);
      test_reset();
      test_tx_overflow();
      test_rx_irq();
      test_withdraw();
      test_back_to_back();
      test_rx_full_collision();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end
endmodule
